// File: rtl/data_mem_if.sv
// data_mem_if - request/response bundle between a requester and the data
// memory responder.
//   master : drives req_valid/req_we/req_addr/req_wdata and rsp_ready
//   slave  : drives req_ready, rsp_valid/rsp_rdata/rsp_err
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [14:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder - single-outstanding word memory with fixed response
// latency.
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset (storage itself is not reset)
//   bus    : data_mem_if.slave; a request is accepted in IDLE when req_valid
//            is high, and the response is presented LATENCY cycles later
//            until rsp_ready is seen.
// Parameters: DEPTH words of 32 bits (power of two), LATENCY 1..15.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          in_range;
  logic [AW-1:0] idx;

  assign accept   = (state_q == IDLE) && bus.req_valid;
  assign in_range = ({17'b0, bus.req_addr} < DEPTH);
  // Low address bits only index storage once the range check has passed.
  assign idx      = in_range ? bus.req_addr[AW-1:0] : '0;

  // Next state / counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        cnt_d   = 4'(LATENCY - 1);
        state_d = (LATENCY == 1) ? RESP : WAIT;
      end
      // Leaving on cnt==1 puts rsp_valid up LATENCY edges after acceptance.
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Response fields are captured at acceptance and held until the next one.
      if (accept) begin
        err_q   <= !in_range;
        rdata_q <= (!bus.req_we && in_range) ? mem[idx] : 32'h0;
      end
    end
  end

  // Storage is deliberately outside the reset domain: a committed store
  // survives a reset that aborts its response.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && in_range) mem[idx] <= bus.req_wdata;
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench: three responders (LATENCY 2, 1, 15; DEPTH 256). Directed requests
// push expected responses into one scoreboard; a monitor pops and compares
// on every response handshake and checks latency, hold stability and
// req_ready during the response.
module tb_data_mem_responder;
  localparam int N = 3;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errs = 0;
  exp_t sb[$];

  logic [N-1:0]        req_valid, req_we, rsp_ready;
  logic [N-1:0][14:0]  req_addr;
  logic [N-1:0][31:0]  req_wdata;
  logic [N-1:0]        req_ready, rsp_valid, rsp_err;
  logic [N-1:0][31:0]  rsp_rdata;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 15;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_mem_if bus();
    assign bus.req_valid = req_valid[g];
    assign bus.req_we    = req_we[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_wdata = req_wdata[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign req_ready[g]  = bus.req_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_rdata[g]  = bus.rsp_rdata;
    assign rsp_err[g]    = bus.rsp_err;

    data_mem_responder #(.DEPTH(256), .LATENCY(lat_of(g))) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, clear of both edges.
  logic [N-1:0]       vld_d = '0, rdy_d = '0, hold_err = '0;
  logic [N-1:0][31:0] hold_rd = '0;

  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      for (int g = 0; g < N; g++) begin
        if (rsp_valid[g] && !vld_d[g]) begin
          if (sb.size() == 0 || sb[0].id != g)
            chk($sformatf("unexpected_rsp_dut%0d", g), 32'(rsp_valid[g]), 32'd0);
          else
            chk($sformatf("latency_dut%0d", g), 32'(cyc - sb[0].acc + 1), 32'(lat_of(g)));
        end
        if (rsp_valid[g] && vld_d[g] && !rdy_d[g]) begin
          chk($sformatf("hold_rdata_dut%0d", g), rsp_rdata[g], hold_rd[g]);
          chk($sformatf("hold_err_dut%0d", g), 32'(rsp_err[g]), 32'(hold_err[g]));
        end
        if (rsp_valid[g]) chk($sformatf("req_ready_in_resp_dut%0d", g), 32'(req_ready[g]), 32'd0);
        if (rsp_valid[g] && rsp_ready[g] && sb.size() != 0 && sb[0].id == g) begin
          chk($sformatf("rsp_rdata_dut%0d", g), rsp_rdata[g], sb[0].rdata);
          chk($sformatf("rsp_err_dut%0d", g), 32'(rsp_err[g]), 32'(sb[0].err));
          void'(sb.pop_front());
        end
        vld_d[g]    <= rsp_valid[g];
        rdy_d[g]    <= rsp_ready[g];
        hold_rd[g]  <= rsp_rdata[g];
        hold_err[g] <= rsp_err[g];
      end
    end
  end

  task automatic do_req(input int g, input logic we, input logic [14:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input bit push);
    int n = 0;
    @(negedge clk);
    req_we[g] = we; req_addr[g] = a; req_wdata[g] = wd; req_valid[g] = 1'b1;
    while (!req_ready[g] && n < 50) begin @(negedge clk); n++; end
    if (!req_ready[g]) chk("accept_timeout", 32'(req_ready[g]), 32'd1);
    else if (push) sb.push_back('{g, er, ee, cyc + 1});
    @(posedge clk);
    #1 req_valid[g] = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin @(negedge clk); n++; end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    logic [14:0] a;
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; rsp_ready = '1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk("reset_req_ready", 32'(req_ready[g]), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid[g]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[g], 32'd0);
      chk("reset_rsp_err", 32'(rsp_err[g]), 32'd0);
    end
    rst_n = 1'b1;

    // Store then load back
    do_req(0, 1, 15'h0010, 32'hDEADBEEF, 32'h0, 0, 1);
    wait_drain(40);
    do_req(0, 0, 15'h0010, 32'h0, 32'hDEADBEEF, 0, 1);
    wait_drain(40);

    // Out-of-range load/store must not alias onto word 0
    do_req(0, 1, 15'h0000, 32'h11111111, 32'h0, 0, 1);
    do_req(0, 0, 15'h0100, 32'h0, 32'h0, 1, 1);
    wait_drain(40);
    do_req(0, 1, 15'h0100, 32'hCAFEF00D, 32'h0, 1, 1);
    wait_drain(40);
    do_req(0, 0, 15'h0000, 32'h0, 32'h11111111, 0, 1);
    do_req(0, 0, 15'h7FFF, 32'h0, 32'h0, 1, 1);
    wait_drain(40);

    // Backpressure in RESP while req_valid toggles with a store to 0x20
    do_req(0, 1, 15'h0020, 32'hAAAA5555, 32'h0, 0, 1);
    wait_drain(40);
    rsp_ready[0] = 1'b0;
    do_req(0, 0, 15'h0010, 32'h0, 32'hDEADBEEF, 0, 1);
    n = 0;
    while (!rsp_valid[0] && n < 20) begin @(negedge clk); n++; end
    chk("hold_reach_resp", 32'(rsp_valid[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_we[0] = 1'b1; req_addr[0] = 15'h0020; req_wdata[0] = 32'h0;
      req_valid[0] = ~req_valid[0];
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    wait_drain(40);
    do_req(0, 0, 15'h0020, 32'h0, 32'hAAAA5555, 0, 1);
    wait_drain(40);

    // Reset during WAIT: store commits, no response, outputs clear at once
    do_req(0, 1, 15'h0005, 32'h12345678, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_wait_req_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 0, 15'h0010, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    chk("pre_rst_rdata_loaded", rsp_rdata[0], 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("rst_async_rdata", rsp_rdata[0], 32'd0);
    chk("rst_async_err", 32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_req(0, 0, 15'h0005, 32'h0, 32'h12345678, 0, 1);
    wait_drain(40);

    // LATENCY=1 back-to-back loads with req_valid held high
    do_req(1, 1, 15'h0003, 32'h33333333, 32'h0, 0, 1);
    wait_drain(40);
    do_req(1, 1, 15'h0004, 32'h44444444, 32'h0, 0, 1);
    wait_drain(40);
    @(negedge clk);
    req_we[1] = 1'b0;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("b2b_req_ready", 32'(req_ready[1]), 32'(k % 2 == 0));
      if (req_ready[1]) begin
        a = (k % 4 == 0) ? 15'h0003 : 15'h0004;
        req_addr[1] = a;
        sb.push_back('{1, (a == 15'h0003) ? 32'h33333333 : 32'h44444444, 1'b0, cyc + 1});
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    wait_drain(40);

    // LATENCY=15
    do_req(2, 1, 15'h0007, 32'h77777777, 32'h0, 0, 1);
    wait_drain(60);
    do_req(2, 0, 15'h0007, 32'h0, 32'h77777777, 0, 1);
    wait_drain(60);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
